boss_sprite_ctrl: RTL and testbench

Sequencing controller for the boss sprite datapath: owns boss position, movement, hit points and hit-flash state. Generates the per-pixel sprite ROM address and a pixel-aligned sprite-enable for the boss renderer. Sits between game logic (start/hit pulses) and the boss ROM/palette pipeline, clocked on the pixel clock.

---
 rtl/boss_pkg.sv | 16 +
 rtl/boss_addr_gen.sv | 37 +++
 rtl/boss_sprite_ctrl.sv | 163 ++++++++++++++++
 tb/tb_boss_sprite_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boss_pkg.sv
// Shared types and screen constants for the boss sprite controller.
package boss_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENTER,
      PATROL,
      DYING,
      DEAD
   } boss_state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int ROM_AW   = 16;

endpackage

// File: rtl/boss_addr_gen.sv
// Boss bounding-box test and sprite ROM address for the current pixel.
module boss_addr_gen
   import boss_pkg::*;
#(
   parameter int SPRITE_W = 120,
   parameter int SPRITE_H = 90
) (
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [9:0]        boss_x,
   input  logic [9:0]        boss_y,
   input  logic              visible,
   output logic              in_box,
   output logic [ROM_AW-1:0] rom_address
);

   logic [10:0] x_end;
   logic [10:0] y_end;
   logic [9:0]  dx;
   logic [9:0]  dy;

   // 11-bit right/bottom edges so boxes near the screen edge cannot wrap
   assign x_end = {1'b0, boss_x} + 11'(SPRITE_W);
   assign y_end = {1'b0, boss_y} + 11'(SPRITE_H);

   assign in_box = visible
                && (DrawX >= boss_x) && ({1'b0, DrawX} < x_end)
                && (DrawY >= boss_y) && ({1'b0, DrawY} < y_end);

   assign dx = DrawX - boss_x;
   assign dy = DrawY - boss_y;

   assign rom_address = in_box
      ? ROM_AW'(ROM_AW'(dy) * ROM_AW'(SPRITE_W) + ROM_AW'(dx))
      : '0;

endmodule

// File: rtl/boss_sprite_ctrl.sv
// Boss movement, hit points and sprite addressing on the pixel clock.
// Define BOSS_FLASH_EN to enable the hit / death flash output.
module boss_sprite_ctrl
   import boss_pkg::*;
#(
   parameter int SPRITE_W     = 120,
   parameter int SPRITE_H     = 90,
   parameter int PATROL_Y     = 40,
   parameter int X_SPEED      = 2,
   parameter int Y_SPEED      = 1,
   parameter int BOSS_HP      = 16,
   parameter int FLASH_FRAMES = 8,
   parameter int DEATH_FRAMES = 60
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        start,
   input  logic        hit,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [15:0] rom_address,
   output logic        sprite_on,
   output logic        flash,
   output logic [9:0]  boss_x,
   output logic [9:0]  boss_y,
   output logic [7:0]  hp,
   output logic        boss_dead
);

   localparam logic [9:0] X_MAX   = 10'(SCREEN_W - SPRITE_W);
   localparam logic [9:0] X_START = 10'((SCREEN_W - SPRITE_W) / 2);
   localparam logic [9:0] Y_PATROL = 10'(PATROL_Y);

   boss_state_t state_q;
   logic [9:0]  x_q, y_q, x_d, y_d;
   logic        dir_q, dir_d;
   logic [7:0]  hp_q, death_q;
   logic        son_q, in_box, visible, launch;

   assign visible = (state_q == ENTER) || (state_q == PATROL)
                 || (state_q == DYING);
   assign launch  = start && ((state_q == IDLE) || (state_q == DEAD));

   // dir_q: 0 = moving right, 1 = moving left
   always_comb begin
      x_d   = x_q;
      dir_d = dir_q;
      y_d   = y_q;
      if (!dir_q) begin
         if (11'(x_q) + 11'(X_SPEED) >= 11'(X_MAX)) begin
            x_d   = X_MAX;
            dir_d = 1'b1;
         end else begin
            x_d = x_q + 10'(X_SPEED);
         end
      end else begin
         if (x_q <= 10'(X_SPEED)) begin
            x_d   = '0;
            dir_d = 1'b0;
         end else begin
            x_d = x_q - 10'(X_SPEED);
         end
      end
      if (11'(y_q) + 11'(Y_SPEED) >= 11'(Y_PATROL)) y_d = Y_PATROL;
      else                                          y_d = y_q + 10'(Y_SPEED);
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         dir_q   <= 1'b0;
         hp_q    <= '0;
         death_q <= '0;
         son_q   <= 1'b0;
      end else begin
         son_q <= in_box;
         unique case (state_q)
            IDLE, DEAD: begin
               if (start) begin
                  state_q <= ENTER;
                  x_q     <= X_START;
                  y_q     <= '0;
                  dir_q   <= 1'b0;
                  hp_q    <= 8'(BOSS_HP);
                  death_q <= '0;
               end
            end
            ENTER: begin
               if (frame_start) begin
                  y_q <= y_d;
                  if (y_d == Y_PATROL) state_q <= PATROL;
               end
            end
            PATROL: begin
               if (hp_q == '0) begin
                  state_q <= DYING;
                  death_q <= 8'(DEATH_FRAMES);
               end else begin
                  if (frame_start) begin
                     x_q   <= x_d;
                     dir_q <= dir_d;
                  end
                  if (hit) hp_q <= hp_q - 8'd1;
               end
            end
            DYING: begin
               if (frame_start) begin
                  if (death_q <= 8'd1) begin
                     death_q <= '0;
                     state_q <= DEAD;
                  end else begin
                     death_q <= death_q - 8'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef BOSS_FLASH_EN
   logic [7:0] fcnt_q;

   always_ff @(posedge vga_clk) begin
      if (reset || launch) begin
         fcnt_q <= '0;
      end else if (hit && (state_q == PATROL) && (hp_q != '0)) begin
         fcnt_q <= 8'(FLASH_FRAMES);
      end else if (frame_start && (fcnt_q != '0)) begin
         fcnt_q <= fcnt_q - 8'd1;
      end
   end

   // death_q[2] flips every 4 frames while dying
   assign flash = ((state_q == PATROL) && (fcnt_q != '0))
               || ((state_q == DYING) && death_q[2]);
`else
   assign flash = 1'b0;
`endif

   boss_addr_gen #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
   ) u_addr (
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .boss_x      (x_q),
      .boss_y      (y_q),
      .visible     (visible),
      .in_box      (in_box),
      .rom_address (rom_address)
   );

   assign sprite_on = son_q;
   assign boss_x    = x_q;
   assign boss_y    = y_q;
   assign hp        = hp_q;
   assign boss_dead = (state_q == DEAD);

endmodule

// File: tb/tb_boss_sprite_ctrl.sv
// Scenario and randomized checks of boss_sprite_ctrl against a behavioural model.
module tb_boss_sprite_ctrl;

   logic        vga_clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_start = 1'b0;
   logic        start = 1'b0;
   logic        hit = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic [15:0] rom_address;
   logic        sprite_on, flash, boss_dead;
   logic [9:0]  boss_x, boss_y;
   logic [7:0]  hp;

   int n_chk = 0;
   int n_pass = 0;

   boss_sprite_ctrl dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .frame_start (frame_start),
      .start       (start),
      .hit         (hit),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .rom_address (rom_address),
      .sprite_on   (sprite_on),
      .flash       (flash),
      .boss_x      (boss_x),
      .boss_y      (boss_y),
      .hp          (hp),
      .boss_dead   (boss_dead)
   );

   always #5 vga_clk = ~vga_clk;

   localparam int M_IDLE = 0, M_ENTER = 1, M_PATROL = 2, M_DYING = 3, M_DEAD = 4;
`ifdef BOSS_FLASH_EN
   localparam bit FL_EN = 1'b1;
`else
   localparam bit FL_EN = 1'b0;
`endif

   int m_st, m_x, m_y, m_hp, m_dir, m_fc, m_death;
   bit m_son;

   task automatic mreset();
      m_st = M_IDLE; m_x = 0; m_y = 0; m_hp = 0; m_dir = 1;
      m_fc = 0; m_death = 0; m_son = 0;
   endtask

   function automatic bit m_inbox(int dx, int dy);
      bit vis = (m_st == M_ENTER) || (m_st == M_PATROL) || (m_st == M_DYING);
      return vis && dx >= m_x && dx < m_x + 120 && dy >= m_y && dy < m_y + 90;
   endfunction

   function automatic int m_rom(int dx, int dy);
      if (!m_inbox(dx, dy)) return 0;
      return ((dy - m_y) * 120 + (dx - m_x)) % 65536;
   endfunction

   function automatic bit m_flash();
      if (!FL_EN) return 1'b0;
      return (m_st == M_PATROL && m_fc > 0)
          || (m_st == M_DYING && ((m_death / 4) % 2 == 1));
   endfunction

   task automatic mstep(bit fs, bit st, bit ht, int dx, int dy);
      int ns = m_st, nx = m_x, ny = m_y, nh = m_hp;
      int nd = m_dir, nf = m_fc, nde = m_death;
      if (reset) begin mreset(); return; end
      m_son = m_inbox(dx, dy);
      if (ht && m_st == M_PATROL && m_hp > 0) nf = 8;
      else if (fs && m_fc > 0) nf = m_fc - 1;
      case (m_st)
         M_IDLE, M_DEAD:
            if (st) begin
               ns = M_ENTER; nx = 260; ny = 0; nh = 16; nd = 1; nf = 0; nde = 0;
            end
         M_ENTER:
            if (fs) begin
               ny = (m_y + 1 > 40) ? 40 : m_y + 1;
               if (ny == 40) ns = M_PATROL;
            end
         M_PATROL:
            if (m_hp == 0) begin
               ns = M_DYING; nde = 60;
            end else begin
               if (fs) begin
                  nx = m_x + 2 * m_dir;
                  if (nx >= 520) begin nx = 520; nd = -1; end
                  else if (nx <= 0) begin nx = 0; nd = 1; end
               end
               if (ht) nh = m_hp - 1;
            end
         M_DYING:
            if (fs) begin
               nde = m_death - 1;
               if (nde == 0) ns = M_DEAD;
            end
         default: ;
      endcase
      m_st = ns; m_x = nx; m_y = ny; m_hp = nh; m_dir = nd; m_fc = nf; m_death = nde;
   endtask

   task automatic tick(bit fs, bit st, bit ht);
      frame_start = fs; start = st; hit = ht;
      @(posedge vga_clk);
      mstep(fs, st, ht, int'(DrawX), int'(DrawY));
      #1;
      frame_start = 1'b0; start = 1'b0; hit = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(0, 0, 0);
      reset = 1'b0;
      n_chk++; if (boss_x !== 10'd0) $display("FAIL rst_x got %0d exp 0", boss_x); else n_pass++;
      n_chk++; if (boss_y !== 10'd0) $display("FAIL rst_y got %0d exp 0", boss_y); else n_pass++;
      n_chk++; if (hp !== 8'd0) $display("FAIL rst_hp got %0d exp 0", hp); else n_pass++;
      n_chk++; if (boss_dead !== 1'b0) $display("FAIL rst_dead got %b exp 0", boss_dead); else n_pass++;
      n_chk++; if (flash !== 1'b0) $display("FAIL rst_flash got %b exp 0", flash); else n_pass++;
      n_chk++; if (sprite_on !== 1'b0) $display("FAIL rst_son got %b exp 0", sprite_on); else n_pass++;
      for (int i = 0; i < 200; i++) begin
         DrawX = 10'($urandom_range(0, 639));
         DrawY = 10'($urandom_range(0, 479));
         tick(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
         n_chk++;
         if (sprite_on !== 1'b0 || rom_address !== 16'd0 || boss_dead !== 1'b0)
            $display("FAIL idle_sweep son %b rom %0d dead %b exp 0 0 0", sprite_on, rom_address, boss_dead);
         else n_pass++;
      end
   endtask

   task automatic test_enter();
      tick(0, 1, 0);
      n_chk++; if (boss_x !== 10'd260 || boss_y !== 10'd0 || hp !== 8'd16)
         $display("FAIL launch got x%0d y%0d hp%0d exp 260 0 16", boss_x, boss_y, hp); else n_pass++;
      tick(0, 0, 1);
      n_chk++; if (hp !== 8'd16) $display("FAIL enter_hit hp got %0d exp 16", hp); else n_pass++;
      for (int i = 1; i <= 40; i++) begin
         tick(1, 0, 0);
         n_chk++; if (int'(boss_y) !== i) $display("FAIL enter_y got %0d exp %0d", boss_y, i); else n_pass++;
      end
      n_chk++; if (boss_x !== 10'd260) $display("FAIL enter_x got %0d exp 260", boss_x); else n_pass++;
   endtask

   task automatic test_patrol();
      tick(1, 0, 0);
      n_chk++; if (boss_x !== 10'd262 || boss_y !== 10'd40)
         $display("FAIL patrol_first got x%0d y%0d exp 262 40", boss_x, boss_y); else n_pass++;
      for (int i = 1; i < 130; i++) tick(1, 0, 0);
      n_chk++; if (boss_x !== 10'd520) $display("FAIL clamp_x got %0d exp 520", boss_x); else n_pass++;
      tick(1, 0, 0);
      n_chk++; if (boss_x !== 10'd518) $display("FAIL reverse_x got %0d exp 518", boss_x); else n_pass++;
   endtask

   task automatic test_addr();
      DrawX = 10'd0; DrawY = 10'd0;
      tick(0, 0, 0);
      DrawX = boss_x + 10'd5; DrawY = boss_y + 10'd2;
      #1;
      n_chk++; if (rom_address !== 16'd245) $display("FAIL addr got %0d exp 245", rom_address); else n_pass++;
      n_chk++; if (sprite_on !== 1'b0) $display("FAIL son_early got %b exp 0", sprite_on); else n_pass++;
      tick(0, 0, 0);
      n_chk++; if (sprite_on !== 1'b1) $display("FAIL son_late got %b exp 1", sprite_on); else n_pass++;
      DrawX = boss_x + 10'd119;
      tick(0, 0, 0);
      n_chk++; if (sprite_on !== 1'b1 || rom_address !== 16'd359)
         $display("FAIL right_edge son %b rom %0d exp 1 359", sprite_on, rom_address); else n_pass++;
      DrawX = boss_x + 10'd120;
      tick(0, 0, 0);
      n_chk++; if (sprite_on !== 1'b0 || rom_address !== 16'd0)
         $display("FAIL past_edge son %b rom %0d exp 0 0", sprite_on, rom_address); else n_pass++;
   endtask

   task automatic test_same_cycle();
      tick(1, 0, 1);
      n_chk++; if (hp !== 8'd15 || boss_x !== 10'd516)
         $display("FAIL hit_step hp %0d x %0d exp 15 516", hp, boss_x); else n_pass++;
      n_chk++; if (flash !== FL_EN) $display("FAIL flash_on got %b exp %b", flash, FL_EN); else n_pass++;
      for (int i = 1; i < 8; i++) tick(1, 0, 0);
      n_chk++; if (flash !== FL_EN) $display("FAIL flash_hold got %b exp %b", flash, FL_EN); else n_pass++;
      tick(1, 0, 0);
      n_chk++; if (flash !== 1'b0) $display("FAIL flash_off got %b exp 0", flash); else n_pass++;
   endtask

   task automatic test_hits();
      int fx;
      for (int i = 0; i < 15; i++) tick(0, 0, 1);
      n_chk++; if (hp !== 8'd0 || boss_dead !== 1'b0)
         $display("FAIL hp_zero hp %0d dead %b exp 0 0", hp, boss_dead); else n_pass++;
      fx = int'(boss_x);
      tick(1, 0, 1);
      n_chk++; if (hp !== 8'd0 || int'(boss_x) !== fx)
         $display("FAIL dying_entry hp %0d x %0d exp 0 %0d", hp, boss_x, fx); else n_pass++;
      for (int i = 1; i <= 60; i++) begin
         tick(1, 0, 1);
         n_chk++; if (flash !== m_flash()) $display("FAIL dying_flash f%0d got %b exp %b", i, flash, m_flash()); else n_pass++;
         n_chk++; if (boss_dead !== (i == 60)) $display("FAIL dying_dead f%0d got %b exp %b", i, boss_dead, i == 60); else n_pass++;
      end
      n_chk++; if (int'(boss_x) !== fx || hp !== 8'd0)
         $display("FAIL frozen x %0d hp %0d exp %0d 0", boss_x, hp, fx); else n_pass++;
      DrawX = boss_x + 10'd5; DrawY = boss_y + 10'd5;
      tick(0, 0, 0);
      n_chk++; if (sprite_on !== 1'b0 || rom_address !== 16'd0)
         $display("FAIL dead_vis son %b rom %0d exp 0 0", sprite_on, rom_address); else n_pass++;
   endtask

   task automatic test_relaunch();
      tick(0, 1, 0);
      n_chk++; if (boss_x !== 10'd260 || boss_y !== 10'd0 || hp !== 8'd16 || boss_dead !== 1'b0)
         $display("FAIL relaunch x%0d y%0d hp%0d dead%b", boss_x, boss_y, hp, boss_dead); else n_pass++;
      repeat (3) tick(1, 0, 0);
      tick(0, 1, 0);
      n_chk++; if (boss_y !== 10'd3 || hp !== 8'd16)
         $display("FAIL start_ignored y %0d hp %0d exp 3 16", boss_y, hp); else n_pass++;
      reset = 1'b1;
      tick(1, 0, 1);
      reset = 1'b0;
      n_chk++; if (boss_x !== 10'd0 || boss_y !== 10'd0 || hp !== 8'd0 || sprite_on !== 1'b0)
         $display("FAIL mid_reset x%0d y%0d hp%0d son%b exp 0", boss_x, boss_y, hp, sprite_on); else n_pass++;
   endtask

   task automatic test_random();
      int dx, dy;
      for (int i = 0; i < 3000; i++) begin
         dx = m_x + $urandom_range(0, 130) - 5;
         dy = m_y + $urandom_range(0, 100) - 5;
         DrawX = 10'((dx < 0) ? 0 : (dx > 639 ? 639 : dx));
         DrawY = 10'((dy < 0) ? 0 : (dy > 479 ? 479 : dy));
         reset = ($urandom_range(0, 499) == 0);
         tick($urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
         reset = 1'b0;
         n_chk++;
         if (int'(boss_x) !== m_x || int'(boss_y) !== m_y || int'(hp) !== m_hp
             || boss_dead !== (m_st == M_DEAD) || sprite_on !== m_son || flash !== m_flash()
             || int'(rom_address) !== m_rom(int'(DrawX), int'(DrawY)))
            $display("FAIL rand c%0d x%0d/%0d y%0d/%0d hp%0d/%0d dead%b son%b/%b fl%b/%b rom%0d/%0d",
                     i, boss_x, m_x, boss_y, m_y, hp, m_hp, boss_dead, sprite_on, m_son,
                     flash, m_flash(), rom_address, m_rom(int'(DrawX), int'(DrawY)));
         else n_pass++;
      end
   endtask

   initial begin
      mreset();
      repeat (2) @(negedge vga_clk);
      test_reset();
      test_enter();
      test_patrol();
      test_addr();
      test_same_cycle();
      test_hits();
      test_relaunch();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
